// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer for the 2-wide front end.
//
// Owns the program counter and issues one aligned instruction-pair fetch per
// cycle while there is room for the result. Each pair returned by the fetch
// unit (one cycle after its request) is pushed with its PC into an in-order
// queue. Decode drains the queue with valid/ready. A backend redirect flushes
// both queued and in-flight pairs and restarts fetch at the redirect target.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   fetch_pc, fetch_req         request to fetch unit (inst1 @pc, inst2 @pc+4)
//   fetch_inst1, fetch_inst2    fetch unit data, valid the cycle after request
//   redirect_valid, redirect_pc backend redirect (target is 8-byte aligned)
//   dec_valid, dec_ready        queue head handshake toward decode
//   dec_pc, dec_inst1/2         queue head contents
//   fq_count                    queue occupancy (debug)
module fetch_ctrl #(
  parameter int               PC_W     = 8,
  parameter int               INST_W   = 32,
  parameter int               FQ_DEPTH = 4,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [PC_W-1:0]               fetch_pc,
  output logic                          fetch_req,
  input  logic [INST_W-1:0]             fetch_inst1,
  input  logic [INST_W-1:0]             fetch_inst2,
  input  logic                          redirect_valid,
  input  logic [PC_W-1:0]               redirect_pc,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [PC_W-1:0]               dec_pc,
  output logic [INST_W-1:0]             dec_inst1,
  output logic [INST_W-1:0]             dec_inst2,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int PW = $clog2(FQ_DEPTH);

  localparam logic [CW:0]     DEPTH_V = (CW+1)'(FQ_DEPTH);
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(8);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PC_W-1:0]   mem_pc_q    [FQ_DEPTH];
  logic [INST_W-1:0] mem_inst1_q [FQ_DEPTH];
  logic [INST_W-1:0] mem_inst2_q [FQ_DEPTH];

  logic [CW:0] outstanding;
  logic        enq;
  logic        deq;

  // Issue only counts what is already queued or in flight; a dequeue in the
  // same cycle does not free a slot until next cycle.
  assign outstanding = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign fetch_req   = !reset && !redirect_valid && (outstanding < DEPTH_V);
  assign fetch_pc    = pc_q;

  assign dec_valid = (count_q != '0);
  assign dec_pc    = mem_pc_q[head_q];
  assign dec_inst1 = mem_inst1_q[head_q];
  assign dec_inst2 = mem_inst2_q[head_q];
  assign fq_count  = count_q;

  // A return landing in a redirect cycle belongs to the squashed path.
  assign enq = inflight_q && !redirect_valid;
  assign deq = dec_valid && dec_ready;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (fetch_req) begin
        pc_d          = pc_q + PC_STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (enq) tail_d = tail_q + PTR_ONE;
      if (deq) head_d = head_q + PTR_ONE;
      if (enq && !deq)      count_d = count_q + CNT_ONE;
      else if (!enq && deq) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      mem_pc_q[tail_q]    <= inflight_pc_q;
      mem_inst1_q[tail_q] <= fetch_inst1;
      mem_inst2_q[tail_q] <= fetch_inst2;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int PC_W = 8;
  localparam int INST_W = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [PC_W-1:0]   fetch_pc;
  logic              fetch_req;
  logic [INST_W-1:0] fetch_inst1, fetch_inst2;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              dec_valid, dec_ready;
  logic [PC_W-1:0]   dec_pc;
  logic [INST_W-1:0] dec_inst1, dec_inst2;
  logic [2:0]        fq_count;

  fetch_ctrl dut (
    .clk(clk), .reset(reset),
    .fetch_pc(fetch_pc), .fetch_req(fetch_req),
    .fetch_inst1(fetch_inst1), .fetch_inst2(fetch_inst2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_inst1(dec_inst1), .dec_inst2(dec_inst2),
    .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return {24'b0, a} ^ KEY;
  endfunction

  // Reference model: a list of pair addresses waiting for decode, plus the one
  // request (if any) whose data is due back this cycle.
  logic [PC_W-1:0] m_q[$];
  logic [PC_W-1:0] m_pc;
  bit              m_infl;
  logic [PC_W-1:0] m_infl_pc;
  bit              m_known = 0;

  // Fetch unit emulation: answers the previous cycle's request.
  bit              fu_pending = 0;
  logic [PC_W-1:0] fu_pc;

  task automatic cyc(input bit rst, input bit redir, input logic [PC_W-1:0] rpc, input bit rdy);
    bit exp_req;
    bit exp_valid;
    bit hs;
    @(negedge clk);
    reset = rst;
    redirect_valid = redir;
    redirect_pc = rpc;
    dec_ready = rdy;
    if (fu_pending) begin
      fetch_inst1 = mem_word(fu_pc);
      fetch_inst2 = mem_word(fu_pc + 8'd4);
    end else begin
      fetch_inst1 = $urandom;
      fetch_inst2 = $urandom;
    end
    #1;
    exp_req = !rst && !redir && ((m_q.size() + int'(m_infl)) < DEPTH);
    exp_valid = m_q.size() != 0;
    chk("fetch_req", {31'b0, fetch_req}, {31'b0, exp_req});
    if (m_known) begin
      chk("fetch_pc", {24'b0, fetch_pc}, {24'b0, m_pc});
      chk("dec_valid", {31'b0, dec_valid}, {31'b0, exp_valid});
      chk("fq_count", {29'b0, fq_count}, 32'(m_q.size()));
      if (exp_valid) begin
        chk("dec_pc", {24'b0, dec_pc}, {24'b0, m_q[0]});
        chk("dec_inst1", dec_inst1, mem_word(m_q[0]));
        chk("dec_inst2", dec_inst2, mem_word(m_q[0] + 8'd4));
      end
    end
    hs = exp_valid && rdy;
    fu_pending = fetch_req;
    fu_pc = fetch_pc;
    @(posedge clk);
    if (rst) begin
      m_known = 1;
      m_pc = '0;
      m_q.delete();
      m_infl = 0;
    end else if (m_known) begin
      if (redir) begin
        m_q.delete();
        m_infl = 0;
        m_pc = rpc;
      end else begin
        if (hs) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl = exp_req;
        if (exp_req) begin
          m_infl_pc = m_pc;
          m_pc = m_pc + 8'd8;
        end
      end
    end
  endtask

  initial begin
    reset = 1; redirect_valid = 0; redirect_pc = '0; dec_ready = 0;
    fetch_inst1 = '0; fetch_inst2 = '0;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // free-running decode from reset
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1);
    chk("steady_count", {29'b0, fq_count}, 32'd1);

    // backpressure after reset
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
    #1;
    chk("bp_count", {29'b0, fq_count}, 32'd4);
    chk("bp_pc", {24'b0, fetch_pc}, 32'd32);
    chk("bp_head", {24'b0, dec_pc}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);

    // full queue then redirect to 0x40
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 8'h40, 0);
    #1;
    chk("redir_count", {29'b0, fq_count}, 32'd0);
    chk("redir_pc", {24'b0, fetch_pc}, 32'h40);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // wrap from 0xF8
    cyc(0, 1, 8'hF8, 1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);

    // redirect coinciding with handshake and an in-flight return
    cyc(0, 1, 8'h80, 1);
    #1;
    chk("redir_hs_count", {29'b0, fq_count}, 32'd0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);

    // single-cycle reset with a full queue
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    #1;
    chk("rst_valid", {31'b0, dec_valid}, 32'd0);
    chk("rst_pc", {24'b0, fetch_pc}, 32'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, rd, dr;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 14) == 0);
      dr = ($urandom_range(0, 9) < 7);
      cyc(r, rd, PC_W'($urandom) & 8'hF8, dr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the 2-wide front end. Owns the program counter, drives the fetch unit's `pc` input one aligned instruction pair per cycle, and captures the returned `inst1`/`inst2` pair into a small in-order fetch queue. Decode drains the queue with a valid/ready handshake. Backend redirects (branch/mispredict) flush all queued and in-flight work.

## Interface
- `PC_W`, default 8: program counter width; byte address, wraps modulo 2^PC_W.
- `INST_W`, default 32: instruction width.
- `FQ_DEPTH`, default 4: fetch queue entries, each holding one instruction pair; power of two, at least 2.
- `RESET_PC`, default 0: PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_pc`  out  PC_W  address sent to the fetch unit (inst1 at pc, inst2 at pc+4).
- `fetch_req`  out  1  `fetch_pc` is a live request this cycle.
- `fetch_inst1`  in  INST_W  fetch unit data for pc; valid the cycle after request.
- `fetch_inst2`  in  INST_W  fetch unit data for pc+4; same timing.
- `redirect_valid`  in  1  backend redirect.
- `redirect_pc`  in  PC_W  new fetch address; bits [2:0] are 0.
- `dec_valid`  out  1  queue head valid.
- `dec_ready`  in  1  decode accepts head.
- `dec_pc`  out  PC_W  PC of head pair.
- `dec_inst1`  out  INST_W  head instruction at `dec_pc`.
- `dec_inst2`  out  INST_W  head instruction at `dec_pc`+4.
- `fq_count`  out  $clog2(FQ_DEPTH+1)  queue occupancy, for debug and verification.

## Operation
- State: `pc`, `inflight` flag plus `inflight_pc`, queue storage, head/tail pointers, and `count`.
- Issue: `fetch_req = !reset && !redirect_valid && (count + inflight) < FQ_DEPTH`. Uses current-cycle values only; no credit is taken for a same-cycle dequeue.
- On issue: `pc <= pc + 8` (mod 2^PC_W), `inflight <= 1`, `inflight_pc <= pc`. With no issue: `inflight <= 0` and `pc` holds.
- Return: when `inflight` is set, `{inflight_pc, fetch_inst1, fetch_inst2}` is written at the tail. The issue rule guarantees the queue is never full at write time.
- Dequeue: `dec_valid = (count != 0)`. Head fields are read combinationally from storage. The head advances on `dec_valid && dec_ready`.
- Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- `fetch_pc` always equals the `pc` register, whether or not `fetch_req` is asserted.
- Redirect (priority over everything except reset):
  - `pc <= redirect_pc`, `count <= 0`, `head <= tail`, `inflight <= 0`.
  - Any return arriving in the redirect cycle is discarded.
  - A `dec_valid && dec_ready` in the redirect cycle counts as consumed by decode; decode is responsible for squashing it.
  - No issue occurs in the redirect cycle.
- Reset: `pc <= RESET_PC`, `count = 0`, pointers `= 0`, `inflight = 0`. A reset mid-operation behaves as a flush; returns arriving during reset are discarded.
- Outputs during and immediately after reset: `fetch_req = 0` (during reset), `dec_valid = 0`, `fetch_pc = RESET_PC`, `fq_count = 0`. `dec_pc`/`dec_inst*` are don't-care while `dec_valid = 0`.

## Timing
- Fetch unit latency is 1 cycle: a request in cycle N returns data in cycle N+1, which is enqueued at the end of N+1. `dec_valid` rises in N+2.
- Reset release: the first cycle with `reset` low is C0. `fetch_req = 1` and `fetch_pc = RESET_PC` in C0; `dec_valid = 1` with `dec_pc = RESET_PC` in C2.
- Redirect asserted in cycle R: `fetch_pc = redirect_pc` and `fetch_req = 1` in R+1. `dec_valid = 1` with the new pair in R+3. `dec_valid = 0` in R+1 and R+2.
- Steady state with `dec_ready = 1`: one pair per cycle, `fq_count` settles at 1.
- Backpressure: at most FQ_DEPTH pairs are outstanding (queued plus in-flight). The request stream stops within one cycle of the queue filling and resumes the cycle after `count + inflight` drops below FQ_DEPTH.
- Ordering: pairs leave in issue order, with no loss or duplication across stalls.

## Test plan
- Reset then `dec_ready = 1` (model memory returns inst = pc ^ 0xA5A5_0000): `fetch_pc` = 0, 8, 16… per cycle from C0. From C2, `dec_pc` = 0, 8, 16… with matching inst1/inst2.
- `dec_ready = 0` for 10 cycles after reset: exactly 4 requests (pc 0, 8, 16, 24), then `fetch_req = 0`, `fetch_pc = 32`, `fq_count = 4`, `dec_pc = 0` held. After release: 0, 8, 16, 24, 32, 40 delivered in order.
- Full queue, then `redirect_valid` with `redirect_pc = 0x40`: next cycle `fq_count = 0`, `dec_valid = 0`, `fetch_pc = 0x40`, `fetch_req = 1`. `dec_pc = 0x40` at R+3; no stale pair ever appears.
- Redirect to 0xF8 with free-running decode: `dec_pc` sequence is 0xF8, 0x00, 0x08 (wrap).
- Redirect in the same cycle as a `dec_ready` handshake and an in-flight return: the returned pair is dropped, and `fq_count = 0` the next cycle.
- `reset` asserted for 1 cycle mid-stream with a full queue: the next cycle shows `dec_valid = 0` and `fetch_pc = RESET_PC`. The restart matches the reset-release timing.
